// File: rtl/mem_arbiter.sv
// Arbitrates the unified 16-bit memory between two-beat instruction fetches and one-beat data accesses.
// Optional fetch anti-starvation counter is enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        me_req,
    input  logic        me_wr,
    input  logic [31:0] me_addr,
    input  logic [15:0] me_wdata,
    output logic        me_done,
    output logic [15:0] me_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_HI = 2'd1,
        IF_LO = 2'd2,
        DATA  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] hi_q;
    logic        kill_q;
    logic        lo_wait;
    logic        fetch_forced;
    logic        grant_data;
    logic        grant_fetch;

`ifdef MEM_ARB_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] starve_q;

    always_comb begin
        fetch_forced = if_req && (starve_q == SW'(STARVE_MAX));
    end

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (grant_fetch) begin
            starve_q <= '0;
        end else if (grant_data && if_req && (starve_q != SW'(STARVE_MAX))) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    always_comb begin
        fetch_forced = 1'b0;
    end
`endif

    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            grant_data  = me_req && !fetch_forced;
            grant_fetch = if_req && !grant_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_q      <= '0;
            kill_q    <= 1'b0;
            lo_wait   <= 1'b0;
            if_valid  <= 1'b0;
            if_data   <= '0;
            me_done   <= 1'b0;
            me_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            me_done  <= 1'b0;
            case (state)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (grant_data) begin
                        state     <= DATA;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= me_wr;
                        mem_addr  <= me_addr;
                        mem_wdata <= me_wdata;
                    end else if (grant_fetch) begin
                        state    <= IF_HI;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= if_addr;
                    end
                end
                IF_HI: begin
                    if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        hi_q    <= mem_rdata;
                        mem_req <= 1'b0;
                        lo_wait <= 1'b1;
                        state   <= IF_LO;
                    end
                end
                IF_LO: begin
                    if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                    // First IF_LO cycle keeps mem_req low so each beat is a distinct request.
                    if (lo_wait) begin
                        lo_wait  <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= mem_addr + 32'd1;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        kill_q  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (!(kill_q || if_kill)) begin
                            if_valid <= 1'b1;
                            if_data  <= {hi_q, mem_rdata};
                        end
                    end
                end
                DATA: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            me_rdata <= mem_rdata;
                        end
                        me_done   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for priority, kill, starvation and asynchronous reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_valid;
    logic [31:0] if_data;
    logic        me_req = 1'b0;
    logic        me_wr = 1'b0;
    logic [31:0] me_addr = '0;
    logic [15:0] me_wdata = '0;
    logic        me_done;
    logic [15:0] me_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_valid(if_valid), .if_data(if_data),
        .me_req(me_req), .me_wr(me_wr), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_done(me_done), .me_rdata(me_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: ack asserted in the lat-th cycle that mem_req is high.
    logic [15:0] mem [256];
    int unsigned lat = 1;
    int unsigned cnt = 0;
    logic [31:0] beat_log [$];

    always_comb mem_ack = mem_req && (cnt == lat - 1);
    always_comb mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else if (mem_ack) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            beat_log.push_back(mem_addr);
            cnt <= 0;
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store
    typedef struct {
        int unsigned kind;
        logic [31:0] addr;
        logic [15:0] wdata;
        int unsigned lat;
        logic [31:0] exp_data;
        int unsigned exp_cyc;
        logic [31:0] exp_a2;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int unsigned n;
        int unsigned req_cyc;
        int unsigned nbeats;
        bit got;
        lat = v.lat;
        beat_log.delete();
        nbeats = (v.kind == 0) ? 2 : 1;
        if (v.kind == 0) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            me_req = 1'b1; me_wr = (v.kind == 2); me_addr = v.addr; me_wdata = v.wdata;
        end
        n = 0; req_cyc = 0; got = 0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (mem_req && (mem_we == (v.kind == 2))) req_cyc++;
            if ((v.kind == 0) ? if_valid : me_done) got = 1;
        end
        chk("latency", n, v.exp_cyc);
        chk("req_cycles", req_cyc, v.lat * nbeats);
        if (v.kind == 0) chk("if_data", if_data, v.exp_data);
        if (v.kind == 1) chk("me_rdata", {16'h0, me_rdata}, v.exp_data);
        if_req = 1'b0; me_req = 1'b0; me_wr = 1'b0;
        tick();
        chk("pulse_width", {30'h0, if_valid, me_done}, 32'h0);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk("beat_count", beat_log.size(), nbeats);
        if (beat_log.size() >= 1) chk("beat0_addr", beat_log[0], v.addr);
        if (v.kind == 0 && beat_log.size() >= 2) chk("beat1_addr", beat_log[1], v.exp_a2);
    endtask

    initial begin
        int unsigned done_n;
        int unsigned valid_n;
        int unsigned vcount;
        logic [15:0] req_hist;
        logic [31:0] a_at3;
        logic [11:0] pat;
        bit found;
        vec_t kv;

        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hABCD; mem[8'h11] = 16'h1234;
        mem[8'hFF] = 16'hBEEF; mem[8'h00] = 16'hCAFE;
        mem[8'h30] = 16'h1357;
        mem[8'h40] = 16'h2468; mem[8'h41] = 16'h9ABC;

        vecs[0] = '{0, 32'h0000_0010, 16'h0,    1, 32'hABCD_1234, 4, 32'h0000_0011};
        vecs[1] = '{0, 32'hFFFF_FFFF, 16'h0,    1, 32'hBEEF_CAFE, 4, 32'h0000_0000};
        vecs[2] = '{1, 32'h0000_0030, 16'h0,    1, 32'h0000_1357, 2, 32'h0};
        vecs[3] = '{2, 32'h0000_0020, 16'h5A5A, 3, 32'h0,         4, 32'h0};
        vecs[4] = '{1, 32'h0000_0020, 16'h0,    2, 32'h0000_5A5A, 3, 32'h0};
        vecs[5] = '{0, 32'h0000_0040, 16'h0,    2, 32'h2468_9ABC, 6, 32'h0000_0041};

        // Reset state
        tick(); tick();
        chk("rst_ctrl", {27'h0, if_valid, me_done, mem_req, mem_we, busy}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_me_rdata", {16'h0, me_rdata}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Simultaneous load and fetch: data first, one idle cycle, then fetch
        lat = 1; beat_log.delete();
        me_req = 1'b1; me_wr = 1'b0; me_addr = 32'h30;
        if_req = 1'b1; if_addr = 32'h10;
        done_n = 0; valid_n = 0; req_hist = '0; a_at3 = '0;
        for (int unsigned n = 1; n <= 12; n++) begin
            tick();
            req_hist[n] = mem_req;
            if (n == 3) a_at3 = mem_addr;
            if (me_done) begin
                done_n = n;
                chk("sim_me_rdata", {16'h0, me_rdata}, 32'h1357);
                me_req = 1'b0;
            end
            if (if_valid) begin
                valid_n = n;
                chk("sim_if_data", if_data, 32'hABCD_1234);
                if_req = 1'b0;
            end
        end
        chk("sim_done_cycle", done_n, 2);
        chk("sim_gap", {29'h0, req_hist[3:1]}, 32'b101);
        chk("sim_fetch_addr", a_at3, 32'h10);
        chk("sim_valid_cycle", valid_n, 6);

        // Kill during IF_HI: second beat still issued, no if_valid
        lat = 2; beat_log.delete();
        if_req = 1'b1; if_addr = 32'h10;
        vcount = 0;
        for (int unsigned n = 1; n <= 10; n++) begin
            tick();
            if (if_valid) vcount++;
            if (n == 1) begin if_kill = 1'b1; if_req = 1'b0; end
            else if_kill = 1'b0;
        end
        chk("kill_no_valid", vcount, 0);
        chk("kill_beats", beat_log.size(), 2);
        if (beat_log.size() >= 2) chk("kill_lo_addr", beat_log[1], 32'h11);
        chk("kill_idle", {31'h0, busy}, 32'h0);
        kv = vecs[5];
        run_vec(kv);

        // Starvation: both requests held continuously
        rst = 1'b1; tick(); rst = 1'b0; tick();
        lat = 1; beat_log.delete();
        me_req = 1'b1; me_wr = 1'b0; me_addr = 32'h30;
        if_req = 1'b1; if_addr = 32'h10;
        for (int unsigned n = 0; n < 80 && beat_log.size() < 12; n++) tick();
        pat = '0;
        for (int unsigned i = 0; i < 12; i++)
            pat = {pat[10:0], (i < beat_log.size()) ? (beat_log[i] == 32'h30) : 1'b0};
`ifdef MEM_ARB_STARVE_EN
        chk("starve_pattern", {20'h0, pat}, 32'hF3C);
`else
        chk("starve_pattern", {20'h0, pat}, 32'hFFF);
`endif
        me_req = 1'b0; if_req = 1'b0;
        for (int unsigned n = 0; n < 20 && (busy || if_valid || me_done); n++) tick();
        tick();
        chk("starve_drain", {30'h0, busy, mem_req}, 32'h0);

        // Asynchronous reset in the middle of IF_LO
        lat = 3; beat_log.delete();
        if_req = 1'b1; if_addr = 32'h10;
        found = 0;
        for (int unsigned n = 0; n < 20 && !found; n++) begin
            tick();
            if (beat_log.size() == 1 && mem_req) found = 1;
        end
        chk("rst_reach_lo", {31'h0, found}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {29'h0, mem_req, busy, if_valid}, 32'h0);
        if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_release", {30'h0, busy, mem_req}, 32'h0);
        kv = vecs[4];
        run_vec(kv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single 16-bit-wide unified memory between the fetch stage (32-bit instruction, two beats) and the memory stage (16-bit load/store, one beat). It owns the memory request/acknowledge handshake, assembles instruction words, gives the memory stage priority, and raises per-requester completion pulses that the pipeline unit uses for stalls. It sits between `fetch_unit`/`mem_unit` and the memory macro.

## Interface
- `STARVE_MAX`, default 4. Consecutive data grants allowed while fetch is waiting before fetch is forced; used only with `MEM_ARB_STARVE_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held high with `if_addr` stable until `if_valid`.
- `if_addr` in 32: halfword address of the instruction's high half.
- `if_kill` in 1: discard the current fetch (jump taken).
- `if_valid` out 1: one-cycle pulse; `if_data` is valid.
- `if_data` out 32: registered instruction, `{hi, lo}`.
- `me_req` in 1: data request. Held with `me_wr`, `me_addr` and `me_wdata` stable until `me_done`.
- `me_wr` in 1: 1 for a store, 0 for a load.
- `me_addr` in 32: data halfword address.
- `me_wdata` in 16: store data.
- `me_done` out 1: one-cycle completion pulse.
- `me_rdata` out 16: registered load data, valid with `me_done` and held afterwards.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: write strobe for the beat.
- `mem_addr` out 32: beat address.
- `mem_wdata` out 16: beat write data.
- `mem_rdata` in 16: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: beat complete. Arrives 1 or more cycles after `mem_req` rises.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE.
  - IF_HI: beat at `if_addr`.
  - IF_LO: beat at `if_addr+1`.
  - DATA: one beat at `me_addr`.
- IDLE arbitration, evaluated each cycle:
  - `me_req` goes to DATA. Data wins because it is the older instruction.
  - Otherwise `if_req` goes to IF_HI.
  - Otherwise stay in IDLE.
- IF_HI + `mem_ack`:
  - Capture `mem_rdata` into hi.
  - Go to IF_LO unconditionally. A fetch is never split by a data beat.
- IF_LO + `mem_ack`:
  - Capture lo.
  - Pulse `if_valid` next cycle unless killed.
  - Return to IDLE.
- DATA + `mem_ack`:
  - For a load, capture `me_rdata`.
  - Pulse `me_done` next cycle.
  - Return to IDLE.
- `mem_req` is high in IF_HI, IF_LO and DATA until `mem_ack`. It is low for exactly one cycle after each ack, because IDLE or the next state re-asserts it.
- `mem_we` = `me_wr` in DATA, 0 otherwise.
- `mem_wdata` = `me_wdata` in DATA, 0 otherwise.
- Address arithmetic is 32-bit modulo: `0xFFFFFFFF+1` wraps to `0`.
- Kill handling:
  - `if_kill` in any cycle of IF_HI/IF_LO sets a kill flag.
  - The outstanding beat still completes, because memory cannot abort.
  - The flag suppresses `if_valid` and clears on return to IDLE.
  - `if_kill` in IDLE has no effect.
- Simultaneous `me_req` and `if_req` in IDLE: DATA is served first, then IF_HI.
- A fetch already in IF_HI/IF_LO when `me_req` rises completes both beats first.
- Reset mid-operation:
  - All state is discarded and the FSM returns to IDLE.
  - `mem_req` drops immediately (asynchronous).
  - Memory must tolerate an abandoned beat.
- Reset values:
  - All outputs are 0: `if_valid`, `if_data`, `me_done`, `me_rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
  - FSM is in IDLE; kill flag and starve counter are 0.

## Timing
- Decision latency: a request seen in IDLE at edge N drives `mem_req` from N+1.
- With 1-cycle ack, a fetch takes 4 cycles from `if_req` to `if_valid`:
  - cycles 1–2: IF_HI (req, ack)
  - cycles 3–4: IF_LO (req, ack)
  - `if_valid` on the edge after the IF_LO ack.
- With 1-cycle ack, a data beat takes 2 cycles from `me_req` to `me_done`.
- `if_valid` and `me_done` are registered single-cycle pulses. The requester must drop or change its request in the pulse cycle. A request still high in the pulse cycle is treated as new in the following IDLE cycle.
- No combinational path from `mem_ack`/`mem_rdata` to any output.

## Configuration
- `MEM_ARB_STARVE_EN`, defined:
  - A counter increments on each DATA grant taken while `if_req` is high.
  - It clears on any IF_HI grant.
  - When the counter equals `STARVE_MAX`, IDLE grants fetch even if `me_req` is high.
- Undefined: strict data priority, no counter. Fetch can starve; the pipeline's own stall of the memory stage prevents this in normal use.

## Test plan
- Fetch only, ack latency 1, `if_addr=0x10`, memory holds `0x10:0xABCD` and `0x11:0x1234`:
  - Beats at `0x10` then `0x11`.
  - `if_data=0xABCD1234`.
  - `if_valid` pulses 4 cycles after `if_req`.
- Load and fetch requested in the same cycle:
  - DATA beat first; `me_done` with `me_rdata` equal to memory content.
  - Then both fetch beats.
  - `mem_req` low exactly one cycle between the data beat and the first fetch beat.
- Store, `me_addr=0x20`, `me_wdata=0x5A5A`, ack latency 3:
  - `mem_we=1` with `mem_addr=0x20` held 3 cycles.
  - `me_done` one cycle after ack.
  - Readback gives `0x5A5A`.
- `if_kill` asserted during IF_HI:
  - IF_LO beat still issued.
  - No `if_valid`.
  - FSM returns to IDLE.
  - Next `if_req` is served normally.
- `if_addr=0xFFFFFFFF`: second beat address is `0x00000000`.
- With `MEM_ARB_STARVE_EN` and `STARVE_MAX=4`, `me_req` and `if_req` held continuously:
  - Exactly 4 data beats, then one fetch, repeating.
  - Without the macro: fetch is never granted.
- `rst` asserted mid-IF_LO: `mem_req`, `busy` and `if_valid` all go to 0 asynchronously; FSM is in IDLE after release.
